mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single 8-bit memory bus between two requesters: the instruction-fetch port (F, read-only) and the execute port (E, read/write).
- Replaces ad-hoc bus muxing in the CPU top.
- Grants one transaction at a time with E priority, plus a starvation guard so fetch cannot be locked out indefinitely.
- Registers all bus outputs and returns per-port completion pulses with captured read data.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles F may wait while E is being granted before F wins the next arbitration.
- TIMEOUT_CYCLES, 16: bus-cycle timeout. Used only when MEM_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- f_req  in  1  fetch request; held until f_ready.
- f_addr  in  8  fetch address.
- f_rdata  out  8  fetch read data; valid with f_ready.
- f_ready  out  1  one-cycle fetch completion pulse.
- f_err  out  1  fetch timeout flag; valid with f_ready.
- e_req  in  1  exec request; held until e_ready.
- e_we  in  1  exec write enable.
- e_addr  in  8  exec address.
- e_wdata  in  8  exec write data.
- e_rdata  out  8  exec read data; valid with e_ready.
- e_ready  out  1  one-cycle exec completion pulse.
- e_err  out  1  exec timeout flag; valid with e_ready.
- mem_req  out  1  bus request to memory.
- mem_addr  out  8  bus address.
- mem_we  out  1  bus write.
- mem_wdata  out  8  bus write data.
- mem_oe  out  1  drive-enable for the top-level tristate (equals mem_we while in BUS_E).
- mem_rdata  in  8  bus read data.
- mem_ready  in  1  memory completion; sampled only while mem_req=1.

Behaviour:
- Reset (async, rst=1):
  - State=IDLE, starvation counter=0, timeout counter=0.
  - All outputs 0, including rdata registers.
  - A transaction in flight is abandoned with no ready pulse; mem_req drops immediately.
- States: IDLE, BUS_F, BUS_E, RELEASE.
- IDLE:
  - If e_req and (f_req=0 or starve_cnt<STARVE_LIMIT): go to BUS_E.
  - Else if f_req: go to BUS_F.
  - Else stay in IDLE.
  - On transition, latch the requester's addr/we/wdata into mem_* and set mem_req=1 (all registered).
- BUS_x:
  - mem_req=1; mem_addr/mem_we/mem_wdata held stable.
  - mem_we=1 only in BUS_E with latched e_we=1; fetch never writes.
  - On mem_ready=1:
    - Capture mem_rdata into x_rdata (writes capture too; the value is don't-care).
    - Pulse x_ready for exactly one cycle, x_err=0.
    - Clear mem_req/mem_we/mem_oe.
    - Go to RELEASE.
- RELEASE:
  - One bus turnaround cycle, mem_req=0.
  - Requesters must drop req in this cycle. A req still high is treated as a new transaction at the next IDLE.
  - Then go to IDLE.
- Latency:
  - req sampled at edge n gives mem_req high after edge n.
  - mem_ready sampled at edge m gives x_ready high after edge m.
  - Minimum req-to-ready is 2 cycles.
  - Back-to-back throughput: one transaction per 3 cycles, plus memory wait.
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments each cycle f_req=1 and state is not BUS_F.
  - Clears when BUS_F is entered.
- Simultaneous e_req and f_req in IDLE: E wins unless starve_cnt==STARVE_LIMIT.
- A request deasserting before ready is a protocol violation; the arbiter completes the latched transaction regardless.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in BUS_x.
  - If TIMEOUT_CYCLES cycles pass without mem_ready: drop mem_req, pulse x_ready with x_err=1, set x_rdata=8'hFF, go to RELEASE.
  - The counter clears on entry to BUS_x.
- Undefined:
  - BUS_x waits indefinitely.
  - f_err/e_err tied to 0.
  - No timeout counter logic is present. Ports are identical in both builds.

Decomposition:
- Shared package eightbit_pkg holds:
  - arb_state_t enum (IDLE, BUS_F, BUS_E, RELEASE).
  - Port-ID constants PORT_F=0 and PORT_E=1.
  - Bus width constant DATA_W=8.
- One natural sub-module: arb_sat_counter, a saturating counter with clear, increment and limit inputs and an at_limit output. It is instantiated for starvation and, when enabled, for timeout.

Test Plan:
- Single fetch: f_req=1, f_addr=8'h10, memory returns 8'hA5 one cycle after mem_req → mem_addr=8'h10, mem_we=0, f_ready pulse 1 cycle, f_rdata=8'hA5.
- Exec write: e_req=1, e_we=1, e_addr=8'h40, e_wdata=8'h3C → mem_we=1, mem_oe=1, mem_wdata=8'h3C; e_ready pulse; RELEASE cycle shows mem_req=0.
- Contention: e_req and f_req rise in the same cycle → BUS_E granted first, then BUS_F after RELEASE; f_ready follows e_ready by ≥3 cycles.
- Starvation: e_req held continuously for 6 transactions with f_req held, STARVE_LIMIT=4 → F is granted no later than the arbitration following 4 wait cycles; counter clears.
- Reset mid-transaction: rst pulsed while in BUS_E awaiting mem_ready → mem_req=0 asynchronously, no e_ready pulse, next grant starts cleanly from IDLE.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): mem_ready never asserted → after 16 cycles x_ready=1, x_err=1, x_rdata=8'hFF. Without the macro, mem_req stays high indefinitely.

Source files
------------

// File: rtl/eightbit_pkg.sv
// Shared definitions for the 8-bit memory bus arbiter: arbitration states,
// requester port indices and the bus data width.
package eightbit_pkg;

    localparam int DATA_W = 8;

    // Requester indices into the per-port completion registers
    localparam int PORT_F = 0;
    localparam int PORT_E = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_F   = 2'd1,
        BUS_E   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear. Stops at 'limit' and reports
// at_limit while it sits there. Clear has priority over increment.
module arb_sat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         at_limit
);

    logic [W-1:0] count;

    // Count up on inc, hold at the limit, clear on request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != limit)) begin
            count <= count + W'(1);
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory bus arbiter: exec port (E) has priority over fetch port (F),
// with a starvation guard that hands the bus to F once it has waited
// STARVE_LIMIT cycles. One transaction at a time, all bus outputs registered,
// one turnaround cycle after every completion.
// Build option: define MEM_ARB_TIMEOUT_EN to abort a bus cycle that sees no
// mem_ready for TIMEOUT_CYCLES cycles (completes with err=1, rdata=8'hFF).
module mem_arbiter
    import eightbit_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [DATA_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_ready,
    output logic              f_err,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [DATA_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic [DATA_W-1:0] e_rdata,
    output logic              e_ready,
    output logic              e_err,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state;
    logic [DATA_W-1:0] rdata_q [2];
    logic [1:0]        ready_q;
    logic              starve_at_limit;
    logic              grant_e;
    logic              grant_f;

    // E wins arbitration unless F is also waiting and has hit the starvation limit
    assign grant_e = (state == IDLE) && e_req && (!f_req || !starve_at_limit);
    assign grant_f = (state == IDLE) && f_req && !grant_e;

    arb_sat_counter #(.W(SW)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .clr      (grant_f),
        .inc      (f_req && (state != BUS_F)),
        .limit    (SW'(STARVE_LIMIT)),
        .at_limit (starve_at_limit)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0] err_q;
    logic       in_bus;
    logic       tmo_at_limit;
    logic       timeout;

    assign in_bus = (state == BUS_F) || (state == BUS_E);

    // Limit is one less than the budget so the abort lands on the last waiting cycle
    arb_sat_counter #(.W(TW)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (!in_bus),
        .inc      (in_bus && !mem_ready),
        .limit    (TW'(TIMEOUT_CYCLES - 1)),
        .at_limit (tmo_at_limit)
    );

    assign timeout = tmo_at_limit && !mem_ready;
    assign f_err   = err_q[PORT_F];
    assign e_err   = err_q[PORT_E];
`else
    assign f_err = 1'b0;
    assign e_err = 1'b0;
`endif

    assign f_rdata = rdata_q[PORT_F];
    assign e_rdata = rdata_q[PORT_E];
    assign f_ready = ready_q[PORT_F];
    assign e_ready = ready_q[PORT_E];

    // Arbitration FSM with registered bus and completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            mem_req         <= 1'b0;
            mem_addr        <= '0;
            mem_we          <= 1'b0;
            mem_oe          <= 1'b0;
            mem_wdata       <= '0;
            ready_q         <= '0;
            rdata_q[PORT_F] <= '0;
            rdata_q[PORT_E] <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            err_q           <= '0;
`endif
        end else begin
            ready_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            err_q   <= '0;
`endif
            case (state)
                IDLE: begin
                    if (grant_e) begin
                        state     <= BUS_E;
                        mem_req   <= 1'b1;
                        mem_addr  <= e_addr;
                        mem_we    <= e_we;
                        mem_oe    <= e_we;
                        mem_wdata <= e_wdata;
                    end else if (grant_f) begin
                        state     <= BUS_F;
                        mem_req   <= 1'b1;
                        mem_addr  <= f_addr;
                        mem_we    <= 1'b0;
                        mem_oe    <= 1'b0;
                        mem_wdata <= '0;
                    end
                end
                BUS_F: begin
                    if (mem_ready) begin
                        state           <= RELEASE;
                        mem_req         <= 1'b0;
                        rdata_q[PORT_F] <= mem_rdata;
                        ready_q[PORT_F] <= 1'b1;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (timeout) begin
                        state           <= RELEASE;
                        mem_req         <= 1'b0;
                        rdata_q[PORT_F] <= 8'hFF;
                        ready_q[PORT_F] <= 1'b1;
                        err_q[PORT_F]   <= 1'b1;
                    end
`endif
                end
                BUS_E: begin
                    if (mem_ready) begin
                        state           <= RELEASE;
                        mem_req         <= 1'b0;
                        mem_we          <= 1'b0;
                        mem_oe          <= 1'b0;
                        rdata_q[PORT_E] <= mem_rdata;
                        ready_q[PORT_E] <= 1'b1;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (timeout) begin
                        state           <= RELEASE;
                        mem_req         <= 1'b0;
                        mem_we          <= 1'b0;
                        mem_oe          <= 1'b0;
                        rdata_q[PORT_E] <= 8'hFF;
                        ready_q[PORT_E] <= 1'b1;
                        err_q[PORT_E]   <= 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// phase, all compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;
    import eightbit_pkg::*;

    localparam int STARVE_LIMIT   = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       f_req = 1'b0;
    logic [7:0] f_addr = '0;
    logic [7:0] f_rdata;
    logic       f_ready;
    logic       f_err;
    logic       e_req = 1'b0;
    logic       e_we = 1'b0;
    logic [7:0] e_addr = '0;
    logic [7:0] e_wdata = '0;
    logic [7:0] e_rdata;
    logic       e_ready;
    logic       e_err;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic       mem_oe;
    logic [7:0] mem_rdata = '0;
    logic       mem_ready = 1'b0;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ready(f_ready), .f_err(f_err),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_rdata(e_rdata), .e_ready(e_ready), .e_err(e_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_oe(mem_oe), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: who owns the bus, whether the turnaround gap is pending,
    // how long F has been kept waiting, and what the outputs should show.
    int         owner;        // 0 nobody, 1 fetch, 2 exec
    bit         gap;
    int         f_waited;
    int         busy_cycles;
    bit         x_req, x_we, x_fr, x_er, x_ferr, x_eerr;
    logic [7:0] x_addr, x_wdata, x_frd, x_erd;

    function automatic void reset_model();
        owner = 0; gap = 0; f_waited = 0; busy_cycles = 0;
        x_req = 0; x_we = 0; x_fr = 0; x_er = 0; x_ferr = 0; x_eerr = 0;
        x_addr = '0; x_wdata = '0; x_frd = '0; x_erd = '0;
    endfunction

    function automatic void model_step();
        bit f_waiting;
        bit start_f;
        bit start_e;
        bit done;
        bit timed;
        f_waiting = f_req && (owner != 1);
        start_f = 0; start_e = 0; done = 0; timed = 0;
        x_fr = 0; x_er = 0; x_ferr = 0; x_eerr = 0;
        if (gap) begin
            gap = 0;
        end else if (owner == 0) begin
            if (e_req && (!f_req || f_waited < STARVE_LIMIT)) start_e = 1;
            else if (f_req) start_f = 1;
        end else begin
            if (mem_ready) done = 1;
`ifdef MEM_ARB_TIMEOUT_EN
            else begin
                busy_cycles++;
                if (busy_cycles == TIMEOUT_CYCLES) timed = 1;
            end
`endif
            if (done || timed) begin
                if (owner == 1) begin
                    x_fr = 1; x_ferr = timed; x_frd = timed ? 8'hFF : mem_rdata;
                end else begin
                    x_er = 1; x_eerr = timed; x_erd = timed ? 8'hFF : mem_rdata;
                end
                owner = 0; gap = 1; x_req = 0; x_we = 0;
            end
        end
        if (start_e) begin
            owner = 2; x_req = 1; x_addr = e_addr; x_we = e_we; x_wdata = e_wdata; busy_cycles = 0;
        end else if (start_f) begin
            owner = 1; x_req = 1; x_addr = f_addr; x_we = 0; x_wdata = '0; busy_cycles = 0;
        end
        if (start_f) f_waited = 0;
        else if (f_waiting && f_waited < STARVE_LIMIT) f_waited++;
    endfunction

    task automatic compare_all();
        check("mem_req", mem_req, x_req);
        check("mem_addr", mem_addr, x_addr);
        check("mem_we", mem_we, x_we);
        check("mem_oe", mem_oe, x_we);
        check("mem_wdata", mem_wdata, x_wdata);
        check("f_ready", f_ready, x_fr);
        check("e_ready", e_ready, x_er);
        check("f_err", f_err, x_ferr);
        check("e_err", e_err, x_eerr);
        check("f_rdata", f_rdata, x_frd);
        check("e_rdata", e_rdata, x_erd);
    endtask

    // Inputs are set at the falling edge; advance one rising edge and compare.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int t_e;
        int t_f;
        int e_done;
        int e_at_f;
        int seen;
        reset_model();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        check("reset_mem_req", mem_req, 0);
        rst = 1'b0;
        step();

        // Single fetch, memory answers one cycle after mem_req
        f_req = 1; f_addr = 8'h10;
        step();
        check("fetch_addr", mem_addr, 8'h10);
        check("fetch_we", mem_we, 0);
        mem_ready = 1; mem_rdata = 8'hA5;
        step();
        check("fetch_ready", f_ready, 1);
        check("fetch_rdata", f_rdata, 8'hA5);
        f_req = 0; mem_ready = 0;
        step();
        check("fetch_pulse_len", f_ready, 0);
        step();

        // Exec write
        e_req = 1; e_we = 1; e_addr = 8'h40; e_wdata = 8'h3C;
        step();
        check("write_we", mem_we, 1);
        check("write_oe", mem_oe, 1);
        check("write_wdata", mem_wdata, 8'h3C);
        mem_ready = 1; mem_rdata = 8'h00;
        step();
        check("write_ready", e_ready, 1);
        check("release_mem_req", mem_req, 0);
        e_req = 0; e_we = 0; mem_ready = 0;
        step();
        step();

        // Contention: both rise together, memory always ready
        e_req = 1; e_addr = 8'h51; f_req = 1; f_addr = 8'h61; mem_ready = 1; mem_rdata = 8'h99;
        t_e = -1; t_f = -1;
        for (int i = 0; i < 20 && t_f < 0; i++) begin
            step();
            if (e_ready) begin t_e = i; e_req = 0; end
            if (f_ready) begin t_f = i; f_req = 0; end
        end
        check("contention_e_first", (t_e >= 0 && t_f > t_e), 1);
        check("contention_gap_ge3", (t_f - t_e >= 3), 1);
        mem_ready = 0;
        step();
        step();

        // Starvation: E held for 6 transactions, F held until served
        e_req = 1; e_addr = 8'h70; f_req = 1; f_addr = 8'h80; mem_ready = 1;
        e_done = 0; e_at_f = -1;
        for (int i = 0; i < 60 && e_done < 6; i++) begin
            mem_rdata = 8'($urandom);
            step();
            if (e_ready) e_done++;
            if (f_ready) begin e_at_f = e_done; f_req = 0; end
        end
        check("starve_e_done", e_done, 6);
        check("starve_e_before_f", e_at_f, 2);
        e_req = 0; mem_ready = 0;
        step();
        step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (f_ready) f_req = 0;
            else if (!f_req && $urandom_range(0, 2) == 0) begin f_req = 1; f_addr = 8'($urandom); end
            if (e_ready) e_req = 0;
            else if (!e_req && $urandom_range(0, 2) == 0) begin
                e_req = 1; e_we = 1'($urandom); e_addr = 8'($urandom); e_wdata = 8'($urandom);
            end
            mem_ready = x_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            mem_rdata = 8'($urandom);
            step();
        end
        f_req = 0; e_req = 0; mem_ready = 1;
        for (int i = 0; i < 20 && (owner != 0 || gap); i++) step();
        check("drain_idle", (owner == 0 && !gap), 1);
        mem_ready = 0;
        step();

        // Reset while exec waits on memory
        e_req = 1; e_we = 0; e_addr = 8'h77;
        step();
        check("pre_reset_mem_req", mem_req, 1);
        #2 rst = 1'b1;
        #1 check("async_reset_mem_req", mem_req, 0);
        check("async_reset_e_ready", e_ready, 0);
        reset_model();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0; e_req = 0;
        step();
        e_req = 1; e_addr = 8'h22;
        step();
        mem_ready = 1; mem_rdata = 8'h5A;
        step();
        check("post_reset_rdata", e_rdata, 8'h5A);
        e_req = 0; mem_ready = 0;
        step();
        step();

        // Memory never answers
        e_req = 1; e_we = 0; e_addr = 8'h33; seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (e_ready) begin seen = 1; e_req = 0; end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        check("timeout_ready_seen", seen, 1);
        check("timeout_mem_req", mem_req, 0);
`else
        check("no_timeout_ready", seen, 0);
        check("no_timeout_mem_req", mem_req, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
